// File: rtl/thermo_maj_sel_if.sv
// Bundle of the sample-side and result-side signals of thermo_maj_sel.
//   master : drives in_valid, in1..in4; observes out_valid, out, err
//   slave  : consumes in_valid, in1..in4; drives out_valid, out, err
// TW is the thermometer width, BW the binary result width (2**BW > TW).
interface thermo_maj_sel_if #(
  parameter int TW = 15,
  parameter int BW = 4
);
  logic          in_valid;
  logic [TW-1:0] in1;
  logic [TW-1:0] in2;
  logic [TW-1:0] in3;
  logic [TW-1:0] in4;
  logic          out_valid;
  logic [BW-1:0] out;
  logic          err;

  modport master (
    output in_valid, in1, in2, in3, in4,
    input  out_valid, out, err
  );

  modport slave (
    input  in_valid, in1, in2, in3, in4,
    output out_valid, out, err
  );
endinterface

// File: rtl/thermo_maj_sel.sv
// Second-largest selector for four thermometer-coded samples.
// A per-bit 2-of-4 majority yields the thermometer code of the second-largest
// sample; its popcount is registered as the binary result (1 clock latency,
// full throughput, no backpressure).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over in_valid)
//   bus  : thermo_maj_sel_if.slave
//          in_valid/in1..in4 in, out_valid/out/err out
//          err=1 (out=0) when any valid sample is not a legal thermometer code
module thermo_maj_sel #(
  parameter int TW = 15,
  parameter int BW = 4
) (
  input logic            clk,
  input logic            rst,
  thermo_maj_sel_if.slave bus
);

  logic [TW-1:0] maj;
  logic [BW-1:0] result;
  logic          any_illegal;

  logic          out_valid_q;
  logic [BW-1:0] out_q;
  logic          err_q;

  // A legal code has no 0 directly below a 1, i.e. no "10" pair at [k+1:k].
  function automatic logic is_illegal(input logic [TW-1:0] v);
    return |(v[TW-1:1] & ~v[TW-2:0]);
  endfunction

  // At-least-2-of-4 per bit: any pair of samples both set.
  assign maj = (bus.in1 & bus.in2) | (bus.in1 & bus.in3) | (bus.in1 & bus.in4) |
               (bus.in2 & bus.in3) | (bus.in2 & bus.in4) | (bus.in3 & bus.in4);

  assign any_illegal = is_illegal(bus.in1) | is_illegal(bus.in2) |
                       is_illegal(bus.in3) | is_illegal(bus.in4);

  // Popcount of the majority code; TW < 2**BW so the sum cannot overflow.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned, which would infer a latch.
    result = '0;
    for (int k = 0; k < TW; k++) begin
      result = result + BW'(maj[k]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= any_illegal ? '0 : result;
        err_q <= any_illegal;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_thermo_maj_sel.sv
// Self-checking bench for thermo_maj_sel: directed cases plus randomized
// samples compared against a value-level model (sort four values, take the
// second largest; legality = the word equals the thermometer of its popcount).
module tb_thermo_maj_sel;
  localparam int TW = 15;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thermo_maj_sel_if #(.TW(TW), .BW(BW)) bus ();

  thermo_maj_sel #(.TW(TW), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what out/err should currently hold.
  int exp_out = 0;
  bit exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] therm(input int v);
    logic [31:0] w;
    w = (32'd1 << v) - 32'd1;
    return w[TW-1:0];
  endfunction

  function automatic bit legal(input logic [TW-1:0] w);
    return w == therm($countones(w));
  endfunction

  function automatic int second_largest(input int a, input int b, input int c, input int d);
    int v[4];
    int t;
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[1];
  endfunction

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic apply(input logic [TW-1:0] w1, input logic [TW-1:0] w2,
                       input logic [TW-1:0] w3, input logic [TW-1:0] w4,
                       input bit valid, input string tag);
    bus.in1      = w1;
    bus.in2      = w2;
    bus.in3      = w3;
    bus.in4      = w4;
    bus.in_valid = valid;
    if (valid) begin
      if (legal(w1) && legal(w2) && legal(w3) && legal(w4)) begin
        exp_out = second_largest($countones(w1), $countones(w2),
                                 $countones(w3), $countones(w4));
        exp_err = 1'b0;
      end else begin
        exp_out = 0;
        exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
    check({tag, ".out"},   32'(bus.out),       32'(exp_out));
    check({tag, ".err"},   32'(bus.err),       32'(exp_err));
  endtask

  task automatic apply_v(input int a, input int b, input int c, input int d, input string tag);
    apply(therm(a), therm(b), therm(c), therm(d), 1'b1, tag);
  endtask

  function automatic logic [TW-1:0] rand_word(input bit allow_illegal);
    if (allow_illegal) return TW'($urandom);
    return therm($urandom_range(TW, 0));
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in1 = '1; bus.in2 = '1; bus.in3 = '1; bus.in4 = '1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset.valid", 32'(bus.out_valid), 32'd0);
    check("reset.out",   32'(bus.out),       32'd0);
    check("reset.err",   32'(bus.err),       32'd0);
    rst = 1'b0;

    // Basic and back-to-back directed samples.
    apply_v(1, 2, 4, 15, "basic");
    apply_v(1, 2, 1, 3,  "b2b0");
    apply_v(9, 9, 9, 3,  "b2b1");
    apply_v(7, 10, 11, 0, "b2b2");

    // Equal / duplicate values.
    apply_v(2, 2, 2, 2,     "eq2");
    apply_v(15, 15, 15, 15, "eq15");
    apply_v(0, 0, 0, 0,     "eq0");
    apply_v(1, 1, 1, 3,     "dup113");
    apply_v(1, 1, 2, 2,     "dup1122");

    // Illegal code flags err, next legal sample clears it.
    apply(15'b000000000000101, therm(3), therm(4), therm(5), 1'b1, "illegal");
    apply_v(3, 4, 5, 6, "clear_err");

    // Hold while in_valid is low.
    apply_v(3, 5, 7, 9, "pre_hold");
    apply(therm(1), therm(1), therm(1), therm(1), 1'b0, "hold");

    // Reset wins over in_valid and discards the sample.
    apply_v(12, 13, 14, 15, "pre_rst");
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in1 = therm(15); bus.in2 = therm(15); bus.in3 = therm(15); bus.in4 = therm(15);
    @(posedge clk);
    #1;
    check("rst_mid.valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid.out",   32'(bus.out),       32'd0);
    check("rst_mid.err",   32'(bus.err),       32'd0);
    rst = 1'b0;
    exp_out = 0;
    exp_err = 1'b0;
    apply(therm(15), therm(15), therm(15), therm(15), 1'b0, "post_rst_idle");
    apply_v(4, 8, 2, 6, "post_rst_first");

    // Randomized: mostly legal, occasionally arbitrary words, gaps in in_valid.
    for (int i = 0; i < 1000; i++) begin
      bit bad;
      bit v;
      bad = ($urandom_range(9, 0) == 0);
      v   = ($urandom_range(4, 0) != 0);
      apply(rand_word(bad), rand_word(1'b0), rand_word(1'b0),
            rand_word(bad && $urandom_range(1, 0) == 1), v, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/thermo_maj_sel.md
Name: thermo_maj_sel

Overview:
- Pooling-filter element that takes four thermometer-coded samples and returns the second-largest value as a 4-bit binary code.
- Per thermometer bit position, computes the at-least-2-of-4 majority, which is itself a thermometer code of the second-largest value, then converts that code to binary.
- Output is registered, with one clock of latency. The block sits between the thermometer-coded sample stage and the binary pooled-output stage.

Parameters:
- TW, 15, thermometer width in bits (values 0..TW).
- BW, 4, binary output width; must satisfy 2^BW > TW.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  inputs in1..in4 are valid this cycle
- in1  input  TW  thermometer sample 1; value = number of ones, packed from bit 0 upward
- in2  input  TW  thermometer sample 2
- in3  input  TW  thermometer sample 3
- in4  input  TW  thermometer sample 4
- out_valid  output  1  out and err valid; registered copy of in_valid
- out  output  BW  binary value of the second-largest input
- err  output  1  at least one input was not a legal thermometer code

Behaviour:
- Reset: on a rising clk edge with rst=1, out=0, err=0, out_valid=0. rst has priority over in_valid.
- Legal code: a vector with no position k (0..TW-2) where bit k+1 is 1 and bit k is 0. All-zeros and all-ones are both legal.
- Majority: for each k, m[k] = 1 when at least two of in1[k]..in4[k] are 1.
  - For legal inputs, m is a legal thermometer code equal to the second-largest of the four values.
  - Duplicates count separately, so for {a,a,b,c} with a largest, the result is a.
- Conversion: result = popcount(m), zero-extended to BW bits. The result range is 0..TW.
- Register update on a rising edge with rst=0 and in_valid=1:
  - All four inputs legal: out = result, err = 0.
  - Any input illegal: out = 0, err = 1.
- Register update on a rising edge with rst=0 and in_valid=0: out and err hold their values, and out_valid = 0.
- out_valid follows in_valid one cycle later. Latency is exactly 1 clock. There is no backpressure.
- A new input may be accepted every cycle, giving full throughput.
- Reset asserted mid-stream discards the in-flight sample. The first valid output after reset release appears one cycle after the first in_valid.
- All datapath logic between the input ports and the output registers is combinational. No other state exists.

Test Plan:
- Values {1,2,4,15} (in4 all-ones), in_valid=1 -> next cycle out=0100, err=0, out_valid=1.
- Values {1,2,1,3}, then {9,9,9,3}, then {7,10,11,0} on back-to-back cycles -> outputs 0010, 1001, 1010 on consecutive cycles, each with out_valid=1.
- Equal inputs:
  - all 2 -> out=0010
  - all 15 -> out=1111
  - all 0 -> out=0000
  - {1,1,1,3} -> out=0001
  - {1,1,2,2} -> out=0010
- Illegal code: in1=15'b000000000000101, others legal -> out=0000, err=1. The following legal sample clears err to 0.
- rst=1 while in_valid=1 with {15,15,15,15} -> out=0000, err=0, out_valid=0. in_valid=0 after legal data -> out holds and out_valid=0.
- Random legal thermometer inputs over 1000 cycles -> out equals the sorted second-largest value, compared against a reference model.
